// File: rtl/ulpb_rx_buffer_if.sv
// Handshake and consumer-side signals of the ulpb receive buffer.
// The buffer uses the slave modport; the node/consumer environment uses master.
interface ulpb_rx_buffer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] RX_ADDR;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_REQ;
  logic                  RX_PEND;
  logic                  RX_FAIL;
  logic                  RX_ACK;
  logic [ADDR_WIDTH-1:0] OUT_ADDR;
  logic [DATA_WIDTH-1:0] OUT_DATA;
  logic                  OUT_LAST;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic                  MSG_DROP;

  modport slave (
    input  RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, OUT_READY,
    output RX_ACK, OUT_ADDR, OUT_DATA, OUT_LAST, OUT_VALID, MSG_DROP
  );

  modport master (
    output RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, OUT_READY,
    input  RX_ACK, OUT_ADDR, OUT_DATA, OUT_LAST, OUT_VALID, MSG_DROP
  );
endinterface

// File: rtl/ulpb_rx_buffer.sv
// Receive-side message buffer for a ulpb node. Completes the four-phase
// RX_REQ/RX_ACK handshake, stores words in a FIFO and only exposes words of
// fully received messages. Aborted or overflowing messages are rolled back by
// moving the write pointer back to the commit pointer.
module ulpb_rx_buffer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input logic            CLK,
  input logic            RESETn,
  ulpb_rx_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACK_WAIT, FAIL_WAIT} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, wr_nxt;
  logic [PW-1:0]   commit_ptr, commit_nxt;
  logic [PW-1:0]   rd_ptr;
  logic            rx_ack, ack_nxt;
  logic            dropping, drop_nxt;
  logic            msg_drop, msg_drop_nxt;
  logic            wr_en;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_last [DEPTH];

  logic [PW-1:0] occupancy, committed;
  logic          full, out_valid, pop;

  // Pointers are one bit wider than the index so full and empty differ.
  assign occupancy = wr_ptr - rd_ptr;
  assign committed = commit_ptr - rd_ptr;
  assign full      = (occupancy == PW'(DEPTH));
  assign out_valid = (committed != '0);
  assign pop       = out_valid & bus.OUT_READY;

  // Handshake FSM: next state, pointer rollback/commit and write enable.
  always_comb begin
    state_nxt    = state;
    ack_nxt      = rx_ack;
    wr_nxt       = wr_ptr;
    commit_nxt   = commit_ptr;
    drop_nxt     = dropping;
    msg_drop_nxt = 1'b0;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.RX_FAIL) begin
          wr_nxt    = commit_ptr;
          drop_nxt  = 1'b0;
          ack_nxt   = 1'b1;
          state_nxt = FAIL_WAIT;
        end else if (bus.RX_REQ) begin
          if (dropping) begin
            // Tail of an overflowed message: acknowledge and discard.
            drop_nxt  = bus.RX_PEND;
            ack_nxt   = 1'b1;
            state_nxt = ACK_WAIT;
          end else if (!full) begin
            wr_en  = 1'b1;
            wr_nxt = wr_ptr + 1'b1;
            if (!bus.RX_PEND) commit_nxt = wr_ptr + 1'b1;
            ack_nxt   = 1'b1;
            state_nxt = ACK_WAIT;
          end else if (committed == '0) begin
            // The open message alone fills the FIFO: it can never complete.
            wr_nxt       = commit_ptr;
            msg_drop_nxt = 1'b1;
            drop_nxt     = bus.RX_PEND;
            ack_nxt      = 1'b1;
            state_nxt    = ACK_WAIT;
          end
          // Otherwise stall until the consumer frees space.
        end
      end
      ACK_WAIT: begin
        if (bus.RX_FAIL) begin
          wr_nxt    = commit_ptr;
          drop_nxt  = 1'b0;
          state_nxt = FAIL_WAIT;
        end else if (!bus.RX_REQ) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      FAIL_WAIT: begin
        if (!bus.RX_FAIL) begin
          ack_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and pointers, cleared by the asynchronous reset.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= IDLE;
      rx_ack     <= 1'b0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      dropping   <= 1'b0;
      msg_drop   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rx_ack     <= ack_nxt;
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      dropping   <= drop_nxt;
      msg_drop   <= msg_drop_nxt;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Word storage; contents need no reset since pointers guard every read.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_addr[wr_ptr[AW-1:0]] <= bus.RX_ADDR;
      mem_data[wr_ptr[AW-1:0]] <= bus.RX_DATA;
      mem_last[wr_ptr[AW-1:0]] <= ~bus.RX_PEND;
    end
  end

  assign bus.RX_ACK    = rx_ack;
  assign bus.MSG_DROP  = msg_drop;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_ADDR  = mem_addr[rd_ptr[AW-1:0]];
  assign bus.OUT_DATA  = mem_data[rd_ptr[AW-1:0]];
  assign bus.OUT_LAST  = out_valid & mem_last[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_ulpb_rx_buffer.sv
// Testbench for ulpb_rx_buffer: directed scenarios plus randomized messages
// checked against a queue-based message model.
module tb_ulpb_rx_buffer;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ulpb_rx_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ulpb_rx_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RESETn(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: committed words awaiting pop, words of the open message,
  // and whether the rest of an overflowed message is being thrown away.
  word_t exp_q[$];
  word_t open_q[$];
  word_t got_q[$];
  bit    m_dropping = 0;

  function automatic bit model_word(input word_t w, input bit pend);
    if (m_dropping) begin
      m_dropping = pend;
      return 1'b0;
    end
    if (exp_q.size() + open_q.size() < DEPTH) begin
      w.last = !pend;
      open_q.push_back(w);
      if (!pend) begin
        foreach (open_q[i]) exp_q.push_back(open_q[i]);
        open_q.delete();
      end
      return 1'b0;
    end
    open_q.delete();
    m_dropping = pend;
    return 1'b1;
  endfunction

  function automatic void model_fail();
    open_q.delete();
    m_dropping = 0;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    w.addr = AW'($urandom);
    w.data = $urandom;
    w.last = 1'b0;
    return w;
  endfunction

  // Node-side driver: one full four-phase word transfer.
  task automatic send_word(input word_t w, input bit pend, output int lat,
                           output bit drop_at_ack, output bit drop_after);
    bus.RX_ADDR = w.addr;
    bus.RX_DATA = w.data;
    bus.RX_PEND = pend;
    bus.RX_REQ  = 1'b1;
    lat = 0;
    drop_after = 1'b0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (bus.RX_ACK) break;
    end
    drop_at_ack = bus.MSG_DROP;
    bus.RX_REQ = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (i == 0) drop_after = bus.MSG_DROP;
      if (!bus.RX_ACK) break;
    end
  endtask

  task automatic do_fail(output int lat);
    bus.RX_FAIL = 1'b1;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (bus.RX_ACK) break;
    end
    bus.RX_FAIL = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!bus.RX_ACK) break;
    end
  endtask

  // Consumer-side driver: pop every available word into got_q.
  task automatic pop_all();
    got_q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (!bus.OUT_VALID) break;
      got_q.push_back({bus.OUT_ADDR, bus.OUT_DATA, bus.OUT_LAST});
      bus.OUT_READY = 1'b1;
      @(posedge clk); #1;
      bus.OUT_READY = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.RX_ADDR = '0; bus.RX_DATA = '0; bus.RX_REQ = 0; bus.RX_PEND = 0;
    bus.RX_FAIL = 0; bus.OUT_READY = 0;
    #1 rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.RX_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.RX_ACK); end
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.OUT_VALID); end
    n_cmp++; if (bus.MSG_DROP !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", bus.MSG_DROP); end
    n_cmp++; if (bus.OUT_LAST !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", bus.OUT_LAST); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    word_t w; int lat; bit d0, d1, ed;
    w = '{addr: 8'hef, data: 32'h12345678, last: 1'b0};
    ed = model_word(w, 1'b0);
    send_word(w, 1'b0, lat, d0, d1);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", lat); end
    n_cmp++; if (d0 !== ed) begin n_fail++; $display("FAIL single_drop: got %b want %b", d0, ed); end
    n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.OUT_VALID); end
    n_cmp++; if (bus.OUT_LAST !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", bus.OUT_LAST); end
    n_cmp++; if (bus.OUT_DATA !== 32'h12345678) begin n_fail++; $display("FAIL single_data: got %h want 12345678", bus.OUT_DATA); end
    n_cmp++; if (bus.OUT_ADDR !== 8'hef) begin n_fail++; $display("FAIL single_addr: got %h want ef", bus.OUT_ADDR); end
    pop_all();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    exp_q.delete();
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b want 0", bus.OUT_VALID); end
  endtask

  task automatic test_burst4();
    word_t w; int lat; bit d0, d1, ed;
    for (int k = 0; k < 4; k++) begin
      w = rand_word();
      ed = model_word(w, k < 3);
      send_word(w, k < 3, lat, d0, d1);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL burst_latency%0d: got %0d want 1", k, lat); end
      n_cmp++; if (bus.OUT_VALID !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL burst_valid%0d: got %b want %b", k, bus.OUT_VALID, exp_q.size() != 0); end
    end
    pop_all();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i < exp_q.size()) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_fail();
    word_t w; int lat; bit d0, d1, ed;
    w = rand_word(); ed = model_word(w, 1'b0); send_word(w, 1'b0, lat, d0, d1);
    for (int k = 0; k < 2; k++) begin
      w = rand_word(); ed = model_word(w, 1'b1); send_word(w, 1'b1, lat, d0, d1);
    end
    do_fail(lat);
    model_fail();
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL fail_ack_latency: got %0d want 1", lat); end
    n_cmp++; if (bus.RX_ACK !== 1'b0) begin n_fail++; $display("FAIL fail_ack_release: got %b want 0", bus.RX_ACK); end
    pop_all();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fail_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i < exp_q.size()) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fail_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
    w = rand_word(); ed = model_word(w, 1'b0); send_word(w, 1'b0, lat, d0, d1);
    pop_all();
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL fail_after_msg: got %0d words head %h want 1 word %h", got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]); end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    word_t w; int lat; bit d0, d1, ed;
    for (int k = 0; k < 10; k++) begin
      w = rand_word();
      ed = model_word(w, k < 9);
      send_word(w, k < 9, lat, d0, d1);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ovf_latency%0d: got %0d want 1", k, lat); end
      n_cmp++; if (d0 !== ed) begin n_fail++; $display("FAIL ovf_drop%0d: got %b want %b", k, d0, ed); end
      n_cmp++; if (d1 !== 1'b0) begin n_fail++; $display("FAIL ovf_drop_width%0d: got %b want 0", k, d1); end
      n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL ovf_valid%0d: got %b want 0", k, bus.OUT_VALID); end
    end
    w = rand_word(); ed = model_word(w, 1'b0); send_word(w, 1'b0, lat, d0, d1);
    pop_all();
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL ovf_after_msg: got %0d words head %h want 1 word %h", got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]); end
    exp_q.delete();
  endtask

  task automatic test_stall();
    word_t w, nw, head; int lat; bit d0, d1, ed, any_ack;
    for (int k = 0; k < DEPTH; k++) begin
      w = rand_word(); ed = model_word(w, 1'b0); send_word(w, 1'b0, lat, d0, d1);
    end
    nw = rand_word();
    bus.RX_ADDR = nw.addr; bus.RX_DATA = nw.data; bus.RX_PEND = 1'b0; bus.RX_REQ = 1'b1;
    any_ack = 0;
    repeat (5) begin @(posedge clk); #1; any_ack |= bus.RX_ACK; end
    n_cmp++; if (any_ack !== 1'b0) begin n_fail++; $display("FAIL stall_no_ack: got %b want 0", any_ack); end
    head = {bus.OUT_ADDR, bus.OUT_DATA, bus.OUT_LAST};
    n_cmp++; if (head !== exp_q[0]) begin n_fail++; $display("FAIL stall_head: got %h want %h", head, exp_q[0]); end
    void'(exp_q.pop_front());
    bus.OUT_READY = 1'b1;
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    n_cmp++; if (bus.RX_ACK !== 1'b0) begin n_fail++; $display("FAIL stall_ack_pop_cycle: got %b want 0", bus.RX_ACK); end
    @(posedge clk); #1;
    n_cmp++; if (bus.RX_ACK !== 1'b1) begin n_fail++; $display("FAIL stall_ack_next: got %b want 1", bus.RX_ACK); end
    ed = model_word(nw, 1'b0);
    bus.RX_REQ = 1'b0;
    for (int i = 0; i < 50; i++) begin @(posedge clk); #1; if (!bus.RX_ACK) break; end
    pop_all();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i < exp_q.size()) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    word_t w; int lat; bit d0, d1, ed;
    for (int k = 0; k < 3; k++) begin
      w = rand_word(); ed = model_word(w, 1'b0); send_word(w, 1'b0, lat, d0, d1);
    end
    w = rand_word();
    bus.RX_ADDR = w.addr; bus.RX_DATA = w.data; bus.RX_PEND = 1'b1; bus.RX_REQ = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.RX_ACK !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack_before: got %b want 1", bus.RX_ACK); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.RX_ACK !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", bus.RX_ACK); end
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", bus.OUT_VALID); end
    exp_q.delete(); open_q.delete(); m_dropping = 0;
    bus.RX_REQ = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid_after: got %b want 0", bus.OUT_VALID); end
    w = rand_word(); ed = model_word(w, 1'b0); send_word(w, 1'b0, lat, d0, d1);
    pop_all();
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rstmid_after_msg: got %0d words head %h want 1 word %h", got_q.size(), got_q.size() ? got_q[0] : '0, exp_q[0]); end
    exp_q.delete();
  endtask

  task automatic test_random();
    word_t w; int lat, len, fail_at; bit d0, d1, ed, pend;
    for (int m = 0; m < 40; m++) begin
      len = $urandom_range(1, 12);
      fail_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int k = 0; k < len; k++) begin
        if (!m_dropping && exp_q.size() != 0 && exp_q.size() + open_q.size() == DEPTH) begin
          pop_all();
          n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_mid_count m%0d: got %0d want %0d", m, got_q.size(), exp_q.size()); end
          foreach (got_q[i]) if (i < exp_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_mid_word m%0d/%0d: got %h want %h", m, i, got_q[i], exp_q[i]); end
          end
          exp_q.delete();
        end
        if (k == fail_at) begin
          do_fail(lat);
          model_fail();
          n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rand_fail_latency m%0d: got %0d want 1", m, lat); end
          break;
        end
        w = rand_word();
        pend = (k < len - 1);
        ed = model_word(w, pend);
        send_word(w, pend, lat, d0, d1);
        n_cmp++; if (lat !== 1 || d0 !== ed) begin n_fail++; $display("FAIL rand_word m%0d/%0d: latency %0d drop %b want latency 1 drop %b", m, k, lat, d0, ed); end
      end
      if ($urandom_range(0, 1) == 0 || m == 39) begin
        pop_all();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count m%0d: got %0d want %0d", m, got_q.size(), exp_q.size()); end
        foreach (got_q[i]) if (i < exp_q.size()) begin
          n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word_out m%0d/%0d: got %h want %h", m, i, got_q[i], exp_q[i]); end
        end
        exp_q.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst4();
    test_fail();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
